// File: rtl/friscv_uart_tx_if.sv
// Bus interface between the core's data-memory port and the UART transmitter.
//  we_i    write strobe, one cycle per access
//  re_i    read strobe, one cycle per access
//  addr_i  register byte address
//  wdata_i write data (only [7:0] is meaningful to the UART)
//  rdata_o registered read data returned by the UART
interface friscv_uart_tx_if #(
    parameter int unsigned ADDR_WIDTH = 4
) ();
    logic                  we_i;
    logic                  re_i;
    logic [ADDR_WIDTH-1:0] addr_i;
    logic [31:0]           wdata_i;
    logic [31:0]           rdata_o;

    modport master (
        output we_i,
        output re_i,
        output addr_i,
        output wdata_i,
        input  rdata_o
    );

    modport slave (
        input  we_i,
        input  re_i,
        input  addr_i,
        input  wdata_i,
        output rdata_o
    );
endinterface

// File: rtl/friscv_uart_tx.sv
// Memory-mapped 8N1 UART transmitter with a TX FIFO and a pollable STATUS register.
//  clk    core clock
//  rst_n  asynchronous active-low reset
//  bus    slave side of friscv_uart_tx_if (we_i, re_i, addr_i, wdata_i, rdata_o)
//  tx_o   serial output, idle high, registered
// Register map (addr_i[3:2]): 0 TXDATA (WO), 1 STATUS (RO), 2/3 read as zero.
// STATUS = {28'b0, overflow, busy, empty, full}.
module friscv_uart_tx #(
    parameter int unsigned CLKS_PER_BIT = 434,
    parameter int unsigned FIFO_DEPTH   = 8,
    parameter int unsigned ADDR_WIDTH   = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    friscv_uart_tx_if.slave    bus,
    output logic               tx_o
);

    localparam int unsigned CNT_W  = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
    localparam int unsigned FCNT_W = PTR_W + 1;
    localparam int unsigned IDX_W  = 3;

    localparam logic [1:0] REG_TXDATA = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   baud_q, baud_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [7:0]         shift_q, shift_d;
    logic               tx_q, tx_d;

    logic [7:0]         mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
    logic [FCNT_W-1:0]  count_q, count_d;

    logic               ovf_q, ovf_d;
    logic [31:0]        rdata_q;

    logic [ADDR_WIDTH-1:0] addr_c;
    logic [1:0]         reg_sel_c;
    logic               full_c, empty_c, busy_c, bit_done_c;
    logic               pop_c, push_req_c, push_c, ovf_set_c, status_rd_c;
    logic [31:0]        status_c;
    logic               unused_ok_c;

    // Address decode and FIFO flags
    assign addr_c      = bus.addr_i;
    assign reg_sel_c   = addr_c[3:2];
    assign full_c      = (count_q == FCNT_W'(FIFO_DEPTH));
    assign empty_c     = (count_q == '0);
    assign busy_c      = (state_q != ST_IDLE);
    assign bit_done_c  = (baud_q == CNT_W'(CLKS_PER_BIT - 1));
    assign unused_ok_c = ^{addr_c, bus.wdata_i[31:8]};

    // A push into a full FIFO is still legal when the FSM pops in the same cycle
    assign push_req_c  = bus.we_i & (reg_sel_c == REG_TXDATA);
    assign push_c      = push_req_c & (~full_c | pop_c);
    assign ovf_set_c   = push_req_c & full_c & ~pop_c;
    assign status_rd_c = bus.re_i & (reg_sel_c == REG_STATUS);
    assign status_c    = {28'd0, ovf_q, busy_c, empty_c, full_c};

    // Sticky overflow: a new overflow event beats the read-triggered clear
    assign ovf_d = ovf_set_c | (ovf_q & ~status_rd_c);

    always_comb begin
        count_d = count_q;
        case ({push_c, pop_c})
            2'b10:   count_d = count_q + FCNT_W'(1);
            2'b01:   count_d = count_q - FCNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Transmit FSM; tx_d is the line level for the current state, registered into tx_q
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        tx_d    = 1'b1;
        pop_c   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                baud_d = '0;
                if (!empty_c) begin
                    pop_c   = 1'b1;
                    shift_d = mem_q[rd_ptr_q];
                    state_d = ST_START;
                end
            end
            ST_START: begin
                tx_d = 1'b0;
                if (bit_done_c) begin
                    baud_d  = '0;
                    idx_d   = '0;
                    state_d = ST_DATA;
                end else begin
                    baud_d = baud_q + CNT_W'(1);
                end
            end
            ST_DATA: begin
                tx_d = shift_q[0];
                if (bit_done_c) begin
                    baud_d  = '0;
                    shift_d = {1'b0, shift_q[7:1]};
                    if (idx_q == IDX_W'(7)) begin
                        state_d = ST_STOP;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end else begin
                    baud_d = baud_q + CNT_W'(1);
                end
            end
            ST_STOP: begin
                tx_d = 1'b1;
                if (bit_done_c) begin
                    baud_d = '0;
                    // Chain straight into the next frame so frames stay contiguous
                    if (!empty_c) begin
                        pop_c   = 1'b1;
                        shift_d = mem_q[rd_ptr_q];
                        state_d = ST_START;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    baud_d = baud_q + CNT_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State, datapath and register file
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            baud_q   <= '0;
            idx_q    <= '0;
            shift_q  <= '0;
            tx_q     <= 1'b1;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            rdata_q  <= '0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            if (push_c) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop_c) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            if (bus.re_i) begin
                rdata_q <= (reg_sel_c == REG_STATUS) ? status_c : 32'd0;
            end
        end
    end

    // FIFO storage needs no reset; the pointers define what is valid
    always_ff @(posedge clk) begin
        if (push_c) begin
            mem_q[wr_ptr_q] <= bus.wdata_i[7:0];
        end
    end

    assign tx_o        = tx_q;
    assign bus.rdata_o = rdata_q;

endmodule

// File: tb/tb_friscv_uart_tx.sv
// Scoreboard bench for friscv_uart_tx: accepted bytes are queued as expected frames,
// a line monitor decodes tx_o independently and compares each decoded frame.
module tb_friscv_uart_tx;
    localparam int unsigned CPB   = 4;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned FRAME = 10 * CPB;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic tx;

    friscv_uart_tx_if #(.ADDR_WIDTH(4)) bus_if ();

    friscv_uart_tx #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH),
        .ADDR_WIDTH   (4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if),
        .tx_o  (tx)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [7:0]  exp_q[$];
    int unsigned starts_q[$];
    int          frames = 0;
    bit          mon_abort = 1'b0;
    bit          mon_busy = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Line monitor: samples each bit mid-cell, 10 cells per frame
    initial begin : monitor
        logic [9:0] bits;
        bit aborted;
        forever begin
            @(negedge clk);
            if (rst_n && tx === 1'b0) begin
                mon_busy = 1'b1;
                aborted  = 1'b0;
                starts_q.push_back(cyc);
                for (int k = 0; k < 10; k++) begin
                    repeat ((k == 0) ? 2 : CPB) @(negedge clk);
                    if (mon_abort) begin
                        aborted = 1'b1;
                        break;
                    end
                    bits[k] = tx;
                end
                if (aborted) begin
                    mon_abort = 1'b0;
                end else begin
                    check("start_bit", 32'(bits[0]), 32'd0);
                    check("stop_bit", 32'(bits[9]), 32'd1);
                    if (exp_q.size() == 0) begin
                        n_cmp++;
                        n_err++;
                        $display("FAIL unexpected_frame: got 0x%0h expected none", bits[8:1]);
                    end else begin
                        check("frame_byte", 32'(bits[8:1]), 32'(exp_q.pop_front()));
                    end
                    frames++;
                end
                mon_busy = 1'b0;
            end
        end
    end

    task automatic wr(input logic [3:0] a, input logic [7:0] d);
        @(negedge clk);
        bus_if.we_i    = 1'b1;
        bus_if.re_i    = 1'b0;
        bus_if.addr_i  = a;
        bus_if.wdata_i = {24'($urandom), d};
    endtask

    task automatic bus_idle();
        @(negedge clk);
        bus_if.we_i = 1'b0;
        bus_if.re_i = 1'b0;
    endtask

    task automatic rd(input logic [3:0] a, output logic [31:0] d);
        @(negedge clk);
        bus_if.we_i   = 1'b0;
        bus_if.re_i   = 1'b1;
        bus_if.addr_i = a;
        @(negedge clk);
        bus_if.re_i = 1'b0;
        d = bus_if.rdata_o;
    endtask

    task automatic wait_cyc(input int unsigned target);
        while (cyc < target) @(negedge clk);
    endtask

    task automatic drain(input int budget);
        int c = 0;
        while ((exp_q.size() != 0 || mon_busy) && c < budget) begin
            @(negedge clk);
            c++;
        end
        n_cmp++;
        if (c >= budget) begin
            n_err++;
            $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
        end
        repeat (6) @(negedge clk);
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin : stim
        logic [31:0] d;
        int unsigned t0;
        int          f0;
        int          n;
        logic [7:0]  b;
        int          acc;
        int          lvl;

        bus_if.we_i = 1'b0;
        bus_if.re_i = 1'b0;
        bus_if.addr_i = '0;
        bus_if.wdata_i = '0;
        repeat (3) @(negedge clk);
        check("reset_tx", 32'(tx), 32'd1);
        check("reset_rdata", bus_if.rdata_o, 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        rd(4'h4, d);
        check("status_after_reset", d, 32'h2);

        // Single byte 0x55: exact start timing and busy window
        exp_q.push_back(8'h55);
        wr(4'h0, 8'h55);
        t0 = cyc + 1;
        bus_idle();
        wait_cyc(t0 + 1);
        check("tx_high_after_1", 32'(tx), 32'd1);
        wait_cyc(t0 + 2);
        check("tx_low_at_2", 32'(tx), 32'd0);
        wait_cyc(t0 + 38);
        rd(4'h4, d);
        check("status_busy_e39", d, 32'h6);
        wait_cyc(t0 + 41);
        rd(4'h4, d);
        check("status_idle_e42", d, 32'h2);
        drain(200);

        // Back-to-back frames must be contiguous
        starts_q.delete();
        exp_q.push_back(8'hA5);
        exp_q.push_back(8'h3C);
        wr(4'h0, 8'hA5);
        wr(4'h0, 8'h3C);
        bus_idle();
        drain(300);
        check("b2b_frames", 32'(starts_q.size()), 32'd2);
        if (starts_q.size() == 2) check("b2b_gap", starts_q[1] - starts_q[0], FRAME);

        // Six writes from idle: one in flight, four buffered, sixth dropped
        f0 = frames;
        for (int i = 0; i < 6; i++) begin
            b = 8'($urandom);
            if (i < 5) exp_q.push_back(b);
            wr(4'h0, b);
        end
        rd(4'h4, d);
        check("status_overflow", d, 32'hD);
        rd(4'h4, d);
        check("status_ovf_cleared", d, 32'h5);
        drain(600);
        check("overflow_frames", 32'(frames - f0), 32'd5);

        // Push while full on the STOP->START pop cycle is accepted
        f0 = frames;
        b = 8'($urandom);
        exp_q.push_back(b);
        wr(4'h0, b);
        t0 = cyc + 1;
        for (int i = 0; i < 4; i++) begin
            b = 8'($urandom);
            exp_q.push_back(b);
            wr(4'h0, b);
        end
        bus_idle();
        wait_cyc(t0 + 39);
        b = 8'($urandom);
        exp_q.push_back(b);
        wr(4'h0, b);
        rd(4'h4, d);
        check("status_pop_push", d, 32'h5);
        drain(800);
        check("pop_push_frames", 32'(frames - f0), 32'd6);
        rd(4'h4, d);
        check("status_after_pop_push", d, 32'h2);

        // Unmapped read and ignored write
        f0 = frames;
        rd(4'h4, d);
        check("status_before_unmapped", d, 32'h2);
        repeat (5) @(negedge clk);
        check("rdata_hold", bus_if.rdata_o, 32'h2);
        rd(4'h8, d);
        check("unmapped_read", d, 32'h0);
        wr(4'hC, 8'h77);
        wr(4'h4, 8'h11);
        bus_idle();
        repeat (60) @(negedge clk);
        check("unmapped_no_frame", 32'(frames - f0), 32'd0);
        rd(4'h4, d);
        check("status_after_unmapped", d, 32'h2);

        // Randomized bursts from idle
        for (int it = 0; it < 6; it++) begin
            n = int'($urandom_range(1, 6));
            acc = (n < DEPTH + 1) ? n : DEPTH + 1;
            for (int i = 0; i < n; i++) begin
                b = 8'($urandom);
                if (i < acc) exp_q.push_back(b);
                wr(4'h0, b);
            end
            rd(4'h4, d);
            if (n == 1) begin
                check("burst_status", d, 32'h0);
            end else begin
                lvl = acc - 1;
                check("burst_status", d,
                      {28'd0, (n > DEPTH + 1), 1'b1, (lvl == 0), (lvl == DEPTH)});
            end
            rd(4'h4, d);
            check("burst_ovf_clear", 32'(d[3]), 32'd0);
            drain(600);
        end

        // Reset mid-frame aborts the frame and discards the FIFO
        wr(4'h0, 8'h81);
        t0 = cyc + 1;
        wr(4'h0, 8'h42);
        bus_idle();
        rd(4'h4, d);
        check("status_pre_reset", d, 32'h4);
        wait_cyc(t0 + 4);
        check("tx_low_pre_reset", 32'(tx), 32'd0);
        mon_abort = 1'b1;
        exp_q.delete();
        f0 = frames;
        #1 rst_n = 1'b0;
        #1 check("tx_high_in_reset", 32'(tx), 32'd1);
        repeat (6) @(negedge clk);
        rst_n = 1'b1;
        check("rdata_after_reset", bus_if.rdata_o, 32'd0);
        rd(4'h4, d);
        check("status_after_midreset", d, 32'h2);
        repeat (80) @(negedge clk);
        check("no_frame_after_reset", 32'(frames - f0), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
